axis_edit_buffer: RTL and testbench
===================================

// Module: axis_edit_buffer
// PURPOSE
//  Parametrised single-clock store-and-forward editing engine for the DMA accelerator path.
//  - Captures one AXI-Stream frame from the DMA MM2S channel into an internal buffer.
//  - Applies a per-word edit selected by mode, then replays the frame on the S2MM stream.
//  - Successor to the fixed 32-bit input buffer: adds width/depth parameters, an output
//    stream, early-tlast truncation and four edit modes.
//  - Control/status signals are driven by the AXI-Lite register block.
// PARAMETERS
//  DATA_W  32                     stream data width in bits (multiple of 8)
//  DEPTH   256                    buffer depth in words (power of 2, >=2)
//  LEN_W   $clog2(DEPTH)+1        width of length/count fields
// PORTS
//  aclk          in   1           clock; all ports synchronous to it
//  areset        in   1           asynchronous active-high reset
//  cfg_start     in   1           one-cycle pulse: begin a frame (honoured only in IDLE)
//  cfg_len       in   LEN_W       frame length in words, legal 1..DEPTH
//  cfg_mode      in   2           0 pass, 1 add const, 2 xor const, 3 reverse order
//  cfg_const     in   DATA_W      operand for modes 1/2
//  stat_state    out  2           0 IDLE, 1 LOAD, 2 SEND, 3 DONE
//  stat_done     out  1           one-cycle pulse when the frame is fully sent
//  stat_err      out  1           one-cycle pulse on a rejected start
//  stat_count    out  LEN_W       words captured in the current/last frame
//  s_axis_tready out  1           input handshake
//  s_axis_tdata  in   DATA_W      input data
//  s_axis_tstrb  in   DATA_W/8    ignored; all bytes are treated as valid
//  s_axis_tlast  in   1           input end of frame
//  s_axis_tvalid in   1           input valid
//  m_axis_tvalid out  1           output valid
//  m_axis_tdata  out  DATA_W      output data
//  m_axis_tstrb  out  DATA_W/8    all ones whenever tvalid=1, else 0
//  m_axis_tlast  out  1           high on the final output beat
//  m_axis_tready in   1           output handshake
// BEHAVIOUR
//  - Reset (async assert, released synchronously to aclk):
//    - state=IDLE; pointers and stat_count = 0.
//    - All outputs 0; buffer contents are undefined.
//  - IDLE:
//    - cfg_start with 1<=cfg_len<=DEPTH: latch len, mode and const; clear stat_count;
//      go to LOAD.
//    - cfg_start with cfg_len=0 or cfg_len>DEPTH: stat_err=1 for one cycle; stay IDLE.
//  - LOAD:
//    - s_axis_tready=1. Each accepted beat writes buf[wr_ptr] and increments wr_ptr and
//      stat_count.
//    - Exit to SEND on the beat that makes stat_count==len, or on an accepted tlast,
//      whichever occurs first.
//    - Early tlast: the frame length becomes stat_count.
//    - Beats beyond len: not accepted (tready=0 from the cycle after the final beat).
//  - SEND:
//    - s_axis_tready=0.
//    - Modes 0-2: read buf[0..len-1] in order. Mode 3: read buf[len-1..0].
//    - Edit: mode 0 d; mode 1 (d+const) mod 2^DATA_W, carry discarded;
//      mode 2 d^const; mode 3 d.
//    - First m_axis_tvalid at most 2 cycles after SEND entry.
//    - With tready held high, one beat per cycle with no bubbles.
//    - Hold rule: while tvalid=1 and tready=0, tdata/tlast/tvalid stay stable.
//      tvalid never drops before the handshake.
//    - m_axis_tlast=1 only on beat len. After that beat handshakes: tvalid=0, go to DONE.
//  - DONE: stat_done=1 for exactly one cycle; next state IDLE.
//  - cfg_start outside IDLE: ignored; no stat_err.
//  - len=1: a single beat carries tlast on both sides.
//  - len=DEPTH: wr_ptr wraps to 0 after the last write; that write is not lost.
//  - Reset mid-frame: immediate return to IDLE. m_axis_tvalid and s_axis_tready drop
//    asynchronously.
// TESTING
//  - Mode 0, len=4, inputs 1,2,3,4 with tlast on beat 4 -> out 1,2,3,4; tlast on beat 4;
//    stat_done once.
//  - Mode 1, const=0xFFFFFFFF, inputs 0,1,2 -> out 0xFFFFFFFF,0,1 (wrap); tlast on beat 3.
//  - Mode 3, len=DEPTH=256, inputs 0..255 -> out 255..0; stat_count=256.
//  - Mode 0, len=8, tlast on beat 3 (A,B,C) -> stat_count=3; out A,B,C with tlast on C.
//  - Mode 2, const=0xA5, len=3, random m_axis_tready (50%) -> every stall holds data
//    stable; out = in^0xA5.
//  - Start with len=0 -> stat_err pulse, state stays 0.
//  - Start during SEND -> ignored, no stat_err.
//  - areset pulse mid-LOAD -> all outputs 0; the next frame completes correctly.

Source files
------------

// File: rtl/axis_edit_buffer_if.sv
// AXI-Stream bundle shared by the capture and replay ports
// of the edit buffer.
interface axis_edit_buffer_if #(
   parameter int DATA_W = 32
) ();
   logic                  tvalid;
   logic                  tready;
   logic [DATA_W-1:0]     tdata;
   logic [DATA_W/8-1:0]   tstrb;
   logic                  tlast;

   modport master (
      output tvalid, tdata, tstrb, tlast,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tstrb, tlast,
      output tready
   );
endinterface

// File: rtl/axis_edit_buffer.sv
// Store-and-forward stream editor: captures one frame, then
// replays it with a per-word edit (pass/add/xor/reverse).
module axis_edit_buffer #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int LEN_W  = $clog2(DEPTH) + 1
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              cfg_start,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic [1:0]        cfg_mode,
   input  logic [DATA_W-1:0] cfg_const,
   output logic [1:0]        stat_state,
   output logic              stat_done,
   output logic              stat_err,
   output logic [LEN_W-1:0]  stat_count,
   axis_edit_buffer_if.slave  s_axis,
   axis_edit_buffer_if.master m_axis
);
   localparam int AW     = $clog2(DEPTH);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [1:0]        mode_q, mode_d;
   logic [DATA_W-1:0] const_q, const_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [LEN_W-1:0]  rd_idx_q, rd_idx_d;
   logic              err_q, err_d;
   logic              tvalid_q, tvalid_d;
   logic              tlast_q, tlast_d;
   logic [DATA_W-1:0] tdata_q, tdata_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] edata;
   logic              len_ok;
   logic              unused_strb;

   assign unused_strb = ^s_axis.tstrb;

   assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));

   // Reverse mode walks the buffer from the last captured word down.
   assign rd_addr = (mode_q == 2'd3) ? AW'(len_q - rd_idx_q - LEN_W'(1))
                                     : AW'(rd_idx_q);
   assign rdata = mem[rd_addr];

   always_comb begin
      edata = rdata;
      unique case (mode_q)
         2'd1:    edata = rdata + const_q;
         2'd2:    edata = rdata ^ const_q;
         default: edata = rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      mode_d   = mode_q;
      const_d  = const_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      rd_idx_d = rd_idx_q;
      err_d    = 1'b0;
      tvalid_d = tvalid_q;
      tlast_d  = tlast_q;
      tdata_d  = tdata_q;
      mem_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cfg_start) begin
               if (len_ok) begin
                  len_d    = cfg_len;
                  mode_d   = cfg_mode;
                  const_d  = cfg_const;
                  count_d  = '0;
                  wr_ptr_d = '0;
                  rd_idx_d = '0;
                  state_d  = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            if (s_axis.tvalid) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               count_d  = count_q + LEN_W'(1);
               if ((count_d == len_q) || s_axis.tlast) begin
                  len_d   = count_d;
                  state_d = SEND;
               end
            end
         end
         SEND: begin
            if (tvalid_q && m_axis.tready) begin
               tvalid_d = 1'b0;
               tlast_d  = 1'b0;
               if (tlast_q) state_d = DONE;
            end
            // Refill the output register whenever it is empty or draining.
            if ((!tvalid_q || m_axis.tready) && (rd_idx_q < len_q)) begin
               tvalid_d = 1'b1;
               tdata_d  = edata;
               tlast_d  = (rd_idx_q == len_q - LEN_W'(1));
               rd_idx_d = rd_idx_q + LEN_W'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q  <= IDLE;
         len_q    <= '0;
         mode_q   <= '0;
         const_q  <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         rd_idx_q <= '0;
         err_q    <= 1'b0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         tdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         mode_q   <= mode_d;
         const_q  <= const_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         rd_idx_q <= rd_idx_d;
         err_q    <= err_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         tdata_q  <= tdata_d;
      end
   end

   always_ff @(posedge aclk) begin
      if (mem_we) mem[wr_ptr_q] <= s_axis.tdata;
   end

   assign stat_state    = state_q;
   assign stat_done     = (state_q == DONE);
   assign stat_err      = err_q;
   assign stat_count    = count_q;
   assign s_axis.tready = (state_q == LOAD);
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = tdata_q;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tstrb  = {STRB_W{tvalid_q}};
endmodule

// File: tb/tb_axis_edit_buffer.sv
// Directed bench for axis_edit_buffer: a queue of expected output
// words is filled while loading and drained as beats handshake.
module tb_axis_edit_buffer;
   localparam int DW    = 32;
   localparam int DEPTH = 256;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          aclk = 1'b0;
   logic          areset;
   logic          cfg_start;
   logic [LW-1:0] cfg_len;
   logic [1:0]    cfg_mode;
   logic [DW-1:0] cfg_const;
   logic [1:0]    stat_state;
   logic          stat_done;
   logic          stat_err;
   logic [LW-1:0] stat_count;

   axis_edit_buffer_if #(.DATA_W(DW)) s_if ();
   axis_edit_buffer_if #(.DATA_W(DW)) m_if ();

   axis_edit_buffer #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .aclk       (aclk),
      .areset     (areset),
      .cfg_start  (cfg_start),
      .cfg_len    (cfg_len),
      .cfg_mode   (cfg_mode),
      .cfg_const  (cfg_const),
      .stat_state (stat_state),
      .stat_done  (stat_done),
      .stat_err   (stat_err),
      .stat_count (stat_count),
      .s_axis     (s_if),
      .m_axis     (m_if)
   );

   always #5 aclk = ~aclk;

   int            checks   = 0;
   int            failures = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] din[DEPTH];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] edit(input logic [1:0] mode,
                                          input logic [DW-1:0] c,
                                          input logic [DW-1:0] d);
      case (mode)
         2'd1:    return d + c;
         2'd2:    return d ^ c;
         default: return d;
      endcase
   endfunction

   task automatic start_frame(input int len, input logic [1:0] mode,
                              input logic [DW-1:0] c);
      cfg_start = 1'b1;
      cfg_len   = LW'(len);
      cfg_mode  = mode;
      cfg_const = c;
      @(negedge aclk);
      cfg_start = 1'b0;
   endtask

   // Drives n beats; lastpos (1-based) marks tlast, 0 for none.
   task automatic load(input int n, input int lastpos,
                       input logic [1:0] mode, input logic [DW-1:0] c);
      logic [DW-1:0] e;
      for (int i = 0; i < n; i++) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = din[i];
         s_if.tlast  = (i + 1 == lastpos);
         chk("s_tready_load", s_if.tready, 1);
         e = edit(mode, c, din[i]);
         if (mode == 2'd3) exp_q.push_front(e);
         else exp_q.push_back(e);
         @(negedge aclk);
      end
      s_if.tdata = 32'hDEAD_BEEF;
      s_if.tlast = 1'b0;
      chk("s_tready_beyond", s_if.tready, 0);
      s_if.tvalid = 1'b0;
   endtask

   task automatic collect(input bit rnd, input int exp_cnt, input bit poke);
      int            cyc = 0;
      bit            fin = 0;
      logic          pv  = 1'b0;
      logic          pr  = 1'b1;
      logic [DW-1:0] pd  = '0;
      logic          pl  = 1'b0;
      logic          rdy;
      logic [DW-1:0] e;
      while (!fin && cyc < 3000) begin
         if (poke && cyc == 0) begin
            cfg_start = 1'b1;
            cfg_len   = LW'(2);
         end
         if (poke && cyc == 1) begin
            cfg_start = 1'b0;
            chk("busy_start_err", stat_err, 0);
            chk("busy_start_state", stat_state, 2);
         end
         if (pv && !pr) begin
            chk("hold_valid", m_if.tvalid, 1);
            chk("hold_data", m_if.tdata, pd);
            chk("hold_last", m_if.tlast, pl);
         end
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         m_if.tready = rdy;
         if (m_if.tvalid) begin
            chk("m_tstrb", m_if.tstrb, 4'hF);
            if (rdy) begin
               if (exp_q.size() == 0) begin
                  chk("extra_beat", 1, 0);
                  fin = 1;
               end else begin
                  e = exp_q.pop_front();
                  chk("m_tdata", m_if.tdata, e);
                  chk("m_tlast", m_if.tlast, exp_q.size() == 0);
                  if (m_if.tlast) fin = 1;
               end
            end
         end else begin
            chk("m_tstrb_idle", m_if.tstrb, 0);
         end
         pv = m_if.tvalid;
         pr = rdy;
         pd = m_if.tdata;
         pl = m_if.tlast;
         @(negedge aclk);
         cyc++;
      end
      if (!fin) chk("send_timeout", 0, 1);
      m_if.tready = 1'b0;
      chk("done_pulse", stat_done, 1);
      chk("done_state", stat_state, 3);
      chk("tvalid_after_last", m_if.tvalid, 0);
      chk("stat_count", stat_count, exp_cnt);
      @(negedge aclk);
      chk("done_once", stat_done, 0);
      chk("idle_state", stat_state, 0);
      exp_q.delete();
   endtask

   initial begin
      areset      = 1'b1;
      cfg_start   = 1'b0;
      cfg_len     = '0;
      cfg_mode    = '0;
      cfg_const   = '0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = '0;
      s_if.tlast  = 1'b0;
      s_if.tstrb  = '1;
      m_if.tready = 1'b0;
      @(negedge aclk);
      chk("rst_state", stat_state, 0);
      chk("rst_count", stat_count, 0);
      chk("rst_done", stat_done, 0);
      chk("rst_err", stat_err, 0);
      chk("rst_s_tready", s_if.tready, 0);
      chk("rst_m_tvalid", m_if.tvalid, 0);
      chk("rst_m_tdata", m_if.tdata, 0);
      chk("rst_m_tstrb", m_if.tstrb, 0);
      chk("rst_m_tlast", m_if.tlast, 0);
      areset = 1'b0;
      @(negedge aclk);

      // pass-through, tlast on beat 4, with a start poked during SEND
      for (int i = 0; i < 4; i++) din[i] = DW'(i + 1);
      start_frame(4, 2'd0, '0);
      chk("load_state", stat_state, 1);
      load(4, 4, 2'd0, '0);
      collect(0, 4, 1);

      // add constant with carry wrap
      for (int i = 0; i < 3; i++) din[i] = DW'(i);
      start_frame(3, 2'd1, 32'hFFFF_FFFF);
      load(3, 3, 2'd1, 32'hFFFF_FFFF);
      collect(0, 3, 0);

      // full-depth reverse, exit on count without tlast
      for (int i = 0; i < DEPTH; i++) din[i] = DW'(i);
      start_frame(DEPTH, 2'd3, '0);
      load(DEPTH, 0, 2'd3, '0);
      collect(0, DEPTH, 0);

      // early tlast truncates the frame
      din[0] = 32'hA; din[1] = 32'hB; din[2] = 32'hC;
      start_frame(8, 2'd0, '0);
      load(3, 3, 2'd0, '0);
      collect(0, 3, 0);

      // xor with random output back-pressure
      for (int i = 0; i < 3; i++) din[i] = $urandom;
      start_frame(3, 2'd2, 32'hA5);
      load(3, 3, 2'd2, 32'hA5);
      collect(1, 3, 0);
      for (int i = 0; i < 20; i++) din[i] = $urandom;
      start_frame(20, 2'd2, 32'hA5);
      load(20, 20, 2'd2, 32'hA5);
      collect(1, 20, 0);

      // reverse len=1, single beat carries tlast
      din[0] = 32'h1234_5678;
      start_frame(1, 2'd3, '0);
      load(1, 1, 2'd3, '0);
      collect(0, 1, 0);

      // illegal lengths raise a one-cycle error
      start_frame(0, 2'd0, '0);
      chk("err_len0", stat_err, 1);
      chk("err_len0_state", stat_state, 0);
      @(negedge aclk);
      chk("err_len0_pulse", stat_err, 0);
      start_frame(DEPTH + 1, 2'd0, '0);
      chk("err_len257", stat_err, 1);
      chk("err_len257_state", stat_state, 0);
      @(negedge aclk);

      // reset in the middle of a load
      start_frame(4, 2'd0, '0);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 32'h77;
      repeat (2) @(negedge aclk);
      areset = 1'b1;
      #1;
      chk("mid_rst_state", stat_state, 0);
      chk("mid_rst_count", stat_count, 0);
      chk("mid_rst_s_tready", s_if.tready, 0);
      chk("mid_rst_m_tvalid", m_if.tvalid, 0);
      chk("mid_rst_m_tstrb", m_if.tstrb, 0);
      s_if.tvalid = 1'b0;
      @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      for (int i = 0; i < 4; i++) din[i] = DW'(32'h50 + i);
      start_frame(4, 2'd2, 32'h0F);
      load(4, 4, 2'd2, 32'h0F);
      collect(0, 4, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
